// File: rtl/adc_frame_dispatcher.sv
// Cuts the ADC sample stream into overlapping FRAME_LEN-sample frames, one every HOP
// samples, and deals them round-robin to NUM_CH FFT input buffers with per-channel addresses.
module adc_frame_dispatcher #(
   parameter int NUM_CH    = 3,
   parameter int FRAME_LEN = 1024,
   parameter int HOP       = 512,
   parameter int DATA_W    = 16,
   localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     adc_input_valid,
   input  logic [DATA_W-1:0]        adc_data,
   input  logic [NUM_CH-1:0]        fft_ready,
   output logic [NUM_CH-1:0]        fft_wr_en,
   output logic [NUM_CH*ADDR_W-1:0] fft_wr_addr,
   output logic [DATA_W-1:0]        fft_wr_data,
   output logic [NUM_CH-1:0]        frame_last,
   output logic                     frame_dropped,
   output logic [15:0]              drop_count
);
   localparam int HOP_W = (HOP > 1) ? $clog2(HOP) : 1;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

   if (NUM_CH < (FRAME_LEN + HOP - 1) / HOP) begin : g_bad_cfg
      $error("adc_frame_dispatcher: NUM_CH=%0d cannot hold FRAME_LEN=%0d frames at HOP=%0d",
             NUM_CH, FRAME_LEN, HOP);
   end

   logic [NUM_CH-1:0] active;
   logic [ADDR_W-1:0] idx [NUM_CH];
   logic [HOP_W-1:0]  hop_cnt;
   logic [CH_W-1:0]   next_ch;

   logic              start_slot;
   logic              start_ok;
   logic              start_drop;
   logic [NUM_CH-1:0] wr_sel;
   logic [NUM_CH-1:0] wr_last;
   logic [ADDR_W-1:0] wr_idx [NUM_CH];

   // Handshake: fft_ready[i] is an admission grant sampled only when a frame start lands
   // on channel i; once a frame is admitted its writes are never back-pressured.
   always_comb begin
      start_slot = adc_input_valid && (hop_cnt == '0);
      start_ok   = start_slot && enable && fft_ready[next_ch] && !active[next_ch];
      start_drop = start_slot && enable && !start_ok;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_sel[i]  = adc_input_valid && (active[i] || (start_ok && (next_ch == CH_W'(i))));
         wr_idx[i]  = active[i] ? idx[i] : '0;
         wr_last[i] = wr_sel[i] && (wr_idx[i] == LAST_IDX);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active        <= '0;
         hop_cnt       <= '0;
         next_ch       <= '0;
         drop_count    <= '0;
         fft_wr_en     <= '0;
         fft_wr_addr   <= '0;
         fft_wr_data   <= '0;
         frame_last    <= '0;
         frame_dropped <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            idx[i] <= '0;
         end
      end else begin
         fft_wr_en     <= wr_sel;
         frame_last    <= wr_last;
         frame_dropped <= start_drop;
         if (adc_input_valid) begin
            fft_wr_data <= adc_data;
            hop_cnt     <= (hop_cnt == HOP_W'(HOP - 1)) ? '0 : hop_cnt + 1'b1;
         end
         // next_ch advances on every scheduled start, whether accepted, refused or suppressed
         if (start_slot) begin
            next_ch <= (next_ch == CH_W'(NUM_CH - 1)) ? '0 : next_ch + 1'b1;
         end
         if (start_drop && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_sel[i]) begin
               fft_wr_addr[i*ADDR_W +: ADDR_W] <= wr_idx[i];
               idx[i]                          <= wr_idx[i] + 1'b1;
               active[i]                       <= !wr_last[i];
            end
         end
      end
   end
endmodule
